// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state encoding and sign helpers for iter_divider
// Operands are 33-bit sign-extended; result fields are 40-bit sign-extended.
package div_pkg;

  localparam int DIV_ITERS = 32;
  localparam int MAG_W     = 32;
  localparam int OPND_W    = MAG_W + 1;
  localparam int FIELD_W   = 40;
  localparam int QUO_LSB   = 40;
  localparam int REM_LSB   = 0;
  localparam int DOUT_W    = 2 * FIELD_W;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  // -2^31 maps to 32'h8000_0000, which is its exact magnitude as an unsigned value.
  function automatic logic [MAG_W-1:0] magnitude(input logic [OPND_W-1:0] v);
    return (v[MAG_W-1:0] ^ {MAG_W{v[MAG_W]}}) + {{(MAG_W-1){1'b0}}, v[MAG_W]};
  endfunction

  function automatic logic [FIELD_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                    input logic             neg);
    logic [FIELD_W-1:0] w;
    w = {{(FIELD_W-MAG_W){1'b0}}, mag};
    return neg ? (~w + FIELD_W'(1)) : w;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step of the unsigned divider
// Combinational; the caller supplies the next dividend bit MSB-first.
module div_step
  import div_pkg::*;
(
  input  logic [MAG_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [MAG_W-1:0] divisor,
  output logic [MAG_W-1:0] rem_out,
  output logic             q_bit
);

  logic [MAG_W:0]   trial;
  logic [MAG_W-1:0] rem_sub;

  // rem_in < divisor, so a successful subtraction always fits back in MAG_W bits.
  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, divisor});
    rem_sub = trial[MAG_W-1:0] - divisor;
    rem_out = q_bit ? rem_sub : trial[MAG_W-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - 33-cycle iterative signed/unsigned 32-bit divider with cancel
// ITER_DIVIDER_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor| or divisor is zero.
module iter_divider
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPND_W-1:0] s_axis_dividend_tdata,
  input  logic [OPND_W-1:0] s_axis_divisor_tdata,
  input  logic              s_axis_tvalid,
  input  logic              cancel,
  output logic [DOUT_W-1:0] m_axis_dout_tdata,
  output logic              m_axis_dout_tvalid,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MAG_W-1:0]  quo_q, quo_d;
  logic [MAG_W-1:0]  rem_q, rem_d;
  logic [MAG_W-1:0]  dsr_q, dsr_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [DOUT_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              busy_q, busy_d;

  logic [MAG_W-1:0]  dvd_mag, dsr_mag, step_rem;
  logic              step_q_bit;

  assign dvd_mag = magnitude(s_axis_dividend_tdata);
  assign dsr_mag = magnitude(s_axis_divisor_tdata);

  // quo_q starts as the dividend magnitude; its MSB feeds the step while quotient bits shift in.
  div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[MAG_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid && !cancel) begin
          dsr_d   = dsr_mag;
          qneg_d  = s_axis_dividend_tdata[MAG_W] ^ s_axis_divisor_tdata[MAG_W];
          rneg_d  = s_axis_dividend_tdata[MAG_W];
          dz_d    = (dsr_mag == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          quo_d   = dvd_mag;
          rem_d   = '0;
          state_d = ST_CALC;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
          if ((dsr_mag == '0) || (dvd_mag < dsr_mag)) begin
            quo_d   = '0;
            rem_d   = dvd_mag;
            state_d = ST_FIX;
          end
`endif
        end
      end

      ST_CALC: begin
        if (cancel) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          quo_d = {quo_q[MAG_W-2:0], step_q_bit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!cancel) begin
          tdata_d[QUO_LSB +: FIELD_W] = dz_q ? '1 : apply_sign(quo_q, qneg_q);
          tdata_d[REM_LSB +: FIELD_W] = apply_sign(rem_q, rneg_q);
          tvalid_d = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis_dout_tdata  = tdata_q;
  assign m_axis_dout_tvalid = tvalid_q;
  assign busy               = busy_q;

endmodule
